// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared widths, requester ids and holding-buffer type for the write-back arbiter
package regfile_wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG = 1 << ADDR_W;
  typedef enum logic {REQ_ALU, REQ_MEM} req_e;
  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] dreg;
    logic [DATA_W-1:0] data;
  } wb_buf_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits with set-over-clear precedence and operand hazard lookup
module wb_scoreboard
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_dreg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_dreg,
  input  logic [ADDR_W-1:0] rd_op1,
  input  logic [ADDR_W-1:0] rd_op2,
  output logic              hazard,
  output logic [NREG-1:0]   busy_mask
);
  logic [NREG-1:0] pending_q, pending_d;
  // set applied after clear: a newer issue to the same register stays outstanding
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_dreg] = 1'b0;
    if (set_en) pending_d[set_dreg] = 1'b1;
  end
  always_ff @(posedge clk) pending_q <= !reset ? '0 : pending_d;
  assign busy_mask = pending_q;
  assign hazard = pending_q[rd_op1] | pending_q[rd_op2];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between ALU and load unit
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dreg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dreg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_dreg,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dreg,
  input  logic [ADDR_W-1:0] rd_op1,
  input  logic [ADDR_W-1:0] rd_op2,
  output logic              hazard,
  output logic [NREG-1:0]   busy_mask
);
  wb_buf_t           alu_q, alu_d, mem_q, mem_d;
  req_e              rr_last_q, rr_last_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_dreg_q, rf_dreg_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              alu_gnt, mem_gnt;
  // a granted buffer drains this cycle, so it can accept a refill at the same edge
  always_comb begin
    alu_gnt = alu_q.full & (!mem_q.full | (rr_last_q == REQ_MEM));
    mem_gnt = mem_q.full & (!alu_q.full | (rr_last_q == REQ_ALU));
    alu_ready = reset & (!alu_q.full | alu_gnt);
    mem_ready = reset & (!mem_q.full | mem_gnt);
    alu_d = (alu_valid & alu_ready) ? {1'b1, alu_dreg, alu_data}
                                    : {alu_q.full & !alu_gnt, alu_q.dreg, alu_q.data};
    mem_d = (mem_valid & mem_ready) ? {1'b1, mem_dreg, mem_data}
                                    : {mem_q.full & !mem_gnt, mem_q.dreg, mem_q.data};
    rf_we_d = alu_gnt | mem_gnt;
    rf_dreg_d = alu_gnt ? alu_q.dreg : mem_gnt ? mem_q.dreg : rf_dreg_q;
    rf_wdata_d = alu_gnt ? alu_q.data : mem_gnt ? mem_q.data : rf_wdata_q;
    rr_last_d = alu_gnt ? REQ_ALU : mem_gnt ? REQ_MEM : rr_last_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_q <= '0;
      mem_q <= '0;
      rr_last_q <= REQ_MEM;
      rf_we_q <= 1'b0;
      rf_dreg_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      alu_q <= alu_d;
      mem_q <= mem_d;
      rr_last_q <= rr_last_d;
      rf_we_q <= rf_we_d;
      rf_dreg_q <= rf_dreg_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_dreg = rf_dreg_q;
  assign rf_wdata = rf_wdata_q;
  wb_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue_valid),
    .set_dreg  (issue_dreg),
    .clr_en    (rf_we_q),
    .clr_dreg  (rf_dreg_q),
    .rd_op1    (rd_op1),
    .rd_op2    (rd_op2),
    .hazard    (hazard),
    .busy_mask (busy_mask)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: transaction-level model feeds an expected-write queue checked by a separate monitor
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alu_valid = 1'b1, mem_valid = 1'b1;
  logic alu_ready, mem_ready;
  logic [3:0] alu_dreg = 4'd1, mem_dreg = 4'd2;
  logic [31:0] alu_data = 32'h1234, mem_data = 32'h5678;
  logic rf_we;
  logic [3:0] rf_dreg;
  logic [31:0] rf_wdata;
  logic issue_valid = 1'b0;
  logic [3:0] issue_dreg = '0, rd_op1 = '0, rd_op2 = '0;
  logic hazard;
  logic [15:0] busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dreg(alu_dreg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dreg(mem_dreg), .mem_data(mem_data),
    .rf_we(rf_we), .rf_dreg(rf_dreg), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_dreg(issue_dreg), .rd_op1(rd_op1), .rd_op2(rd_op2),
    .hazard(hazard), .busy_mask(busy_mask)
  );

  typedef struct {logic [3:0] dreg; logic [31:0] data;} ent_t;
  typedef struct {logic [3:0] dreg; logic [31:0] data; int due;} wr_t;
  ent_t alu_m[$], mem_m[$];
  wr_t exp_q[$];
  bit last_alu;
  bit pend[16];
  bit cur_we;
  logic [3:0] cur_dreg = '0, hold_dreg = '0;
  logic [31:0] hold_data = '0;
  bit hold_a, hold_m;
  int cyc, checks, errors;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h cycle %0d", n, act, exp, cyc);
    end
  endfunction

  task automatic model_edge();
    bit a, m, ga, gm;
    ent_t w;
    cyc++;
    a = alu_m.size() > 0;
    m = mem_m.size() > 0;
    ga = a && (!m || !last_alu);
    gm = m && !ga;
    hold_a = reset && alu_valid && a && !ga;
    hold_m = reset && mem_valid && m && !gm;
    if (!reset) begin
      alu_m.delete();
      mem_m.delete();
      last_alu = 1'b0;
      pend = '{default: 1'b0};
      cur_we = 1'b0;
      hold_dreg = '0;
      hold_data = '0;
      return;
    end
    if (cur_we) pend[cur_dreg] = 1'b0;
    if (issue_valid) pend[issue_dreg] = 1'b1;
    cur_we = ga || gm;
    if (cur_we) begin
      w = ga ? alu_m.pop_front() : mem_m.pop_front();
      exp_q.push_back('{dreg: w.dreg, data: w.data, due: cyc});
      cur_dreg = w.dreg;
      hold_dreg = w.dreg;
      hold_data = w.data;
      last_alu = ga;
    end
    if (alu_valid && (!a || ga)) alu_m.push_back('{dreg: alu_dreg, data: alu_data});
    if (mem_valid && (!m || gm)) mem_m.push_back('{dreg: mem_dreg, data: mem_data});
  endtask

  task automatic check_comb();
    logic [15:0] bm;
    bit ea, em;
    for (int i = 0; i < 16; i++) bm[i] = pend[i];
    ea = reset && (alu_m.size() == 0 || mem_m.size() == 0 || !last_alu);
    em = reset && (mem_m.size() == 0 || alu_m.size() == 0 || last_alu);
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, em});
    chk("busy_mask", {16'd0, busy_mask}, {16'd0, bm});
    chk("hazard", {31'd0, hazard}, {31'd0, pend[rd_op1] | pend[rd_op2]});
  endtask

  task automatic step(input bit rs, input bit av, input logic [3:0] ad, input logic [31:0] adat,
                      input bit mv, input logic [3:0] md, input logic [31:0] mdat,
                      input bit iv, input logic [3:0] id, input logic [3:0] o1, input logic [3:0] o2);
    @(posedge clk);
    model_edge();
    #1;
    reset = rs;
    if (!hold_a) begin
      alu_valid = av; alu_dreg = ad; alu_data = adat;
    end
    if (!hold_m) begin
      mem_valid = mv; mem_dreg = md; mem_data = mdat;
    end
    issue_valid = iv; issue_dreg = id; rd_op1 = o1; rd_op2 = o2;
    #1 check_comb();
  endtask

  task automatic idle(input int n, input logic [3:0] o1);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, o1, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got dreg %0h data %0h expected none cycle %0d", rf_dreg, rf_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_dreg", {28'd0, rf_dreg}, {28'd0, e.dreg});
        chk("wr_data", rf_wdata, e.data);
        chk("wr_cycle", cyc, e.due);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write got rf_we %b expected dreg %0h data %0h cycle %0d", rf_we, e.dreg, e.data, cyc);
      end
      chk("hold_dreg", {28'd0, rf_dreg}, {28'd0, hold_dreg});
      chk("hold_data", rf_wdata, hold_data);
    end
  end

  initial begin
    step(0, 1, 4'd1, 32'h1234, 1, 4'd2, 32'h5678, 1, 4'd3, 4'd3, 4'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    step(1, 1, 4'd5, 32'h11, 1, 4'd6, 32'h22, 0, 0, 0, 0);
    idle(3, 0);
    step(1, 1, 4'd3, 32'hAA, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    step(1, 1, 4'd5, 32'h11, 1, 4'd6, 32'h22, 0, 0, 0, 0);
    idle(3, 0);
    for (int i = 1; i <= 4; i++) step(1, 1, 4'(i + 8), 32'(i), 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd7, 0);
    idle(3, 4'd7);
    step(1, 1, 4'd7, 32'h77, 0, 0, 0, 0, 0, 4'd7, 0);
    idle(4, 4'd7);
    step(1, 0, 0, 0, 0, 0, 0, 1, 4'd9, 0, 0);
    step(1, 1, 4'd9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd9, 0);
    idle(2, 4'd9);
    chk("busy9_after_setclr", {31'd0, busy_mask[9]}, 32'd1);
    step(1, 1, 4'd4, 32'h44, 1, 4'd8, 32'h88, 1, 4'd4, 4'd4, 0);
    step(0, 1, 4'd2, 32'h55, 1, 4'd2, 32'h66, 0, 0, 4'd4, 0);
    idle(3, 4'd4);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom), 4'($urandom));
    idle(6, 0);
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
